// File: rtl/mash111_core_if.sv
// Sample/modulator-output bundle for mash111_core: master drives en/din, slave returns dout/dout_vld/c_mon.
// No handshake: en is a strobe and the modulator never stalls.
interface mash111_core_if #(
    parameter int W = 16
) ();
    logic         en;
    logic [W-1:0] din;
    logic [3:0]   dout;
    logic         dout_vld;
    logic [2:0]   c_mon;

    modport master (
        output en,
        output din,
        input  dout,
        input  dout_vld,
        input  c_mon
    );

    modport slave (
        input  en,
        input  din,
        output dout,
        output dout_vld,
        output c_mon
    );
endinterface

// File: rtl/mash111_core.sv
// MASH 1-1-1 sigma-delta modulator: W-bit unsigned in, 4-bit signed (-3..+4) out; optional MASH_DITHER_EN LFSR dither.
// Latency: din sampled on an en edge appears on dout (with a 1-cycle dout_vld pulse) right after that edge.
// Backpressure: none; en=0 freezes all state and holds dout/c_mon.
module mash111_core #(
    parameter int          W    = 16,
    parameter logic [14:0] SEED = 15'h0001
) (
    input logic           clck,
    input logic           rst,
    mash111_core_if.slave bus
);

    logic [W-1:0]       acc1, acc2, acc3;
    logic               c2_d1, c3_d1, c3_d2;
    logic [W:0]         s1, s2, s3;
    logic               d;
    logic signed [3:0]  y;
    logic [3:0]         dout_q;
    logic               dout_vld_q;
    logic [2:0]         c_mon_q;

`ifdef MASH_DITHER_EN
    logic [14:0] lfsr;

    // Fibonacci x^15+x^14+1; steps only with en so gapped streams match gapless ones.
    always_ff @(posedge clck) begin
        if (rst) begin
            lfsr <= SEED;
        end else if (bus.en) begin
            lfsr <= {lfsr[13:0], lfsr[14] ^ lfsr[13]};
        end
    end

    assign d = lfsr[0];
`else
    // No dither: d is constant 0; SEED is folded in only so it stays referenced.
    assign d = ^(SEED & 15'h0000);
`endif

    always_comb begin
        s1 = {1'b0, acc1} + {1'b0, bus.din} + {{W{1'b0}}, d};
        s2 = {1'b0, acc2} + {1'b0, s1[W-1:0]};
        s3 = {1'b0, acc3} + {1'b0, s2[W-1:0]};
        // 4-bit wraparound in the intermediate terms is harmless: the final sum is always in -3..+4.
        y  = $signed({3'b000, s1[W]})
           + $signed({3'b000, s2[W]}) - $signed({3'b000, c2_d1})
           + $signed({3'b000, s3[W]}) - $signed({2'b00, c3_d1, 1'b0})
           + $signed({3'b000, c3_d2});
    end

    always_ff @(posedge clck) begin
        if (rst) begin
            acc1       <= '0;
            acc2       <= '0;
            acc3       <= '0;
            c2_d1      <= 1'b0;
            c3_d1      <= 1'b0;
            c3_d2      <= 1'b0;
            dout_q     <= 4'd0;
            dout_vld_q <= 1'b0;
            c_mon_q    <= 3'd0;
        end else begin
            dout_vld_q <= bus.en;
            if (bus.en) begin
                acc1    <= s1[W-1:0];
                acc2    <= s2[W-1:0];
                acc3    <= s3[W-1:0];
                c2_d1   <= s2[W];
                c3_d2   <= c3_d1;
                c3_d1   <= s3[W];
                dout_q  <= y;
                c_mon_q <= {s3[W], s2[W], s1[W]};
            end
        end
    end

    assign bus.dout     = dout_q;
    assign bus.dout_vld = dout_vld_q;
    assign bus.c_mon    = c_mon_q;

endmodule
